// File: rtl/struct_flat_arbiter.sv
// Round-robin arbiter/sequencer for one shared 12-bit flattened struct datapath
// (field a = [11:4], field b = [3:0]). One transaction is outstanding at a time:
// grant, wait DP_LAT cycles, capture the datapath result, hand it back tagged
// with the requester index over a valid/ready response channel.
// Optional build macro: STRUCT_FLAT_ARB_STATS_EN adds the stat_flat counters port.
module struct_flat_arbiter #(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned ID_W    = 2,
   parameter int unsigned DP_LAT  = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NUM_REQ-1:0]    req_valid,
   input  logic [NUM_REQ*12-1:0] req_data,
   output logic [NUM_REQ-1:0]    req_ready,
   output logic [11:0]           dp_in_flat,
   input  logic [11:0]           dp_out_flat,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [11:0]           rsp_data,
   output logic [ID_W-1:0]       rsp_id,
   output logic                  busy
`ifdef STRUCT_FLAT_ARB_STATS_EN
   ,
   output logic [31:0]           stat_flat
`endif
);

   typedef enum logic [1:0] {StIdle, StIssue, StResp} state_e;

   localparam logic [3:0] LatInit = 4'(DP_LAT - 1);

   state_e            state_q, state_d;
   logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
   logic [3:0]        lat_cnt_q, lat_cnt_d;
   logic [ID_W-1:0]   id_q, id_d;
   logic [11:0]       dp_in_q, dp_in_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic [11:0]       rsp_data_q, rsp_data_d;
   logic [ID_W-1:0]   rsp_id_q, rsp_id_d;

   logic              any_lo, any_hi;
   logic [ID_W-1:0]   win_lo, win_hi, winner;
   logic [11:0]       data_lo, data_hi, win_data;

   // Round-robin pick: lowest valid index at or after rr_ptr, else lowest overall (wrap).
   always_comb begin
      any_lo  = 1'b0;
      any_hi  = 1'b0;
      win_lo  = '0;
      win_hi  = '0;
      data_lo = '0;
      data_hi = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (req_valid[i] && !any_lo) begin
            any_lo  = 1'b1;
            win_lo  = ID_W'(i);
            data_lo = req_data[12*i +: 12];
         end
         if (req_valid[i] && (i >= 32'(rr_ptr_q)) && !any_hi) begin
            any_hi  = 1'b1;
            win_hi  = ID_W'(i);
            data_hi = req_data[12*i +: 12];
         end
      end
      winner   = any_hi ? win_hi : win_lo;
      win_data = any_hi ? data_hi : data_lo;
   end

   // Sequencer next-state and the combinational accept pulse.
   always_comb begin
      state_d     = state_q;
      rr_ptr_d    = rr_ptr_q;
      lat_cnt_d   = lat_cnt_q;
      id_d        = id_q;
      dp_in_d     = dp_in_q;
      rsp_valid_d = rsp_valid_q;
      rsp_data_d  = rsp_data_q;
      rsp_id_d    = rsp_id_q;
      req_ready   = '0;
      unique case (state_q)
         StIdle: begin
            // Gated by rst so no accept is signalled on an edge that reset overrides.
            if (any_lo && !rst) begin
               for (int unsigned i = 0; i < NUM_REQ; i++) begin
                  req_ready[i] = (32'(winner) == i);
               end
               dp_in_d   = win_data;
               id_d      = winner;
               lat_cnt_d = LatInit;
               rr_ptr_d  = (32'(winner) == NUM_REQ - 1) ? '0 : winner + ID_W'(1);
               state_d   = StIssue;
            end
         end
         StIssue: begin
            if (lat_cnt_q == 4'd0) begin
               rsp_data_d  = dp_out_flat;
               rsp_id_d    = id_q;
               rsp_valid_d = 1'b1;
               state_d     = StResp;
            end else begin
               lat_cnt_d = lat_cnt_q - 4'd1;
            end
         end
         StResp: begin
            // Back to IDLE only; the next grant waits a cycle by design.
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               state_d     = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StIdle;
         rr_ptr_q    <= '0;
         lat_cnt_q   <= '0;
         id_q        <= '0;
         dp_in_q     <= '0;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= '0;
         rsp_id_q    <= '0;
      end else begin
         state_q     <= state_d;
         rr_ptr_q    <= rr_ptr_d;
         lat_cnt_q   <= lat_cnt_d;
         id_q        <= id_d;
         dp_in_q     <= dp_in_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_data_q  <= rsp_data_d;
         rsp_id_q    <= rsp_id_d;
      end
   end

   assign dp_in_flat = dp_in_q;
   assign rsp_valid  = rsp_valid_q;
   assign rsp_data   = rsp_data_q;
   assign rsp_id     = rsp_id_q;
   assign busy       = (state_q != StIdle);

`ifdef STRUCT_FLAT_ARB_STATS_EN
   logic [15:0] done_cnt_q, bp_cnt_q;

   // Saturating counters: completed responses and stalled response cycles.
   always_ff @(posedge clk) begin
      if (rst) begin
         done_cnt_q <= '0;
         bp_cnt_q   <= '0;
      end else begin
         if ((state_q == StResp) && rsp_ready && (done_cnt_q != 16'hFFFF)) begin
            done_cnt_q <= done_cnt_q + 16'd1;
         end
         if ((state_q == StResp) && !rsp_ready && (bp_cnt_q != 16'hFFFF)) begin
            bp_cnt_q <= bp_cnt_q + 16'd1;
         end
      end
   end

   assign stat_flat = {done_cnt_q, bp_cnt_q};
`endif

endmodule

// File: tb/tb_struct_flat_arbiter.sv
// Bench for struct_flat_arbiter: one DUT with a combinational loopback datapath
// (DP_LAT = 1) and one with a 3-register datapath (DP_LAT = 4).
// Honours STRUCT_FLAT_ARB_STATS_EN when defined.
module tb_struct_flat_arbiter;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic [3:0]  req_valid, req_ready;
   logic [47:0] req_data;
   logic [11:0] dp_in_flat, rsp_data;
   logic        rsp_valid, rsp_ready, busy;
   logic [1:0]  rsp_id;

   logic [3:0]  l4_req_valid, l4_req_ready;
   logic [47:0] l4_req_data;
   logic [11:0] l4_dp_in, l4_dp_out, l4_rsp_data;
   logic        l4_rsp_valid, l4_rsp_ready, l4_busy;
   logic [1:0]  l4_rsp_id;
   logic [11:0] d1, d2;

`ifdef STRUCT_FLAT_ARB_STATS_EN
   logic [31:0] stat_flat, l4_stat_flat;
`endif

   struct_flat_arbiter #(.NUM_REQ(4), .ID_W(2), .DP_LAT(1)) u_dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_data   (req_data),
      .req_ready  (req_ready),
      .dp_in_flat (dp_in_flat),
      .dp_out_flat(dp_in_flat),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_data   (rsp_data),
      .rsp_id     (rsp_id),
      .busy       (busy)
`ifdef STRUCT_FLAT_ARB_STATS_EN
      ,
      .stat_flat  (stat_flat)
`endif
   );

   struct_flat_arbiter #(.NUM_REQ(4), .ID_W(2), .DP_LAT(4)) u_dut_l4 (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (l4_req_valid),
      .req_data   (l4_req_data),
      .req_ready  (l4_req_ready),
      .dp_in_flat (l4_dp_in),
      .dp_out_flat(l4_dp_out),
      .rsp_valid  (l4_rsp_valid),
      .rsp_ready  (l4_rsp_ready),
      .rsp_data   (l4_rsp_data),
      .rsp_id     (l4_rsp_id),
      .busy       (l4_busy)
`ifdef STRUCT_FLAT_ARB_STATS_EN
      ,
      .stat_flat  (l4_stat_flat)
`endif
   );

   // Three-stage registered datapath for the DP_LAT = 4 instance.
   always @(posedge clk) begin
      d1        <= l4_dp_in;
      d2        <= d1;
      l4_dp_out <= d2;
   end

   int errors = 0;
   int checks = 0;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      req_valid = '0;
      l4_req_valid = '0;
      rsp_ready = 1'b0;
      l4_rsp_ready = 1'b0;
      step();
      step();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      req_valid = 4'hF;
      req_data = 48'h123_456_789_ABC;
      rsp_ready = 1'b1;
      l4_req_valid = '0;
      l4_req_data = '0;
      l4_rsp_ready = 1'b0;
      step();
      step();
      #1;
      checks++;
      if ({req_ready, busy, rsp_valid} !== 6'b0) begin
         errors++;
         $display("FAIL reset_ctrl got=%b exp=000000", {req_ready, busy, rsp_valid});
      end
      checks++;
      if ({dp_in_flat, rsp_data, rsp_id} !== 26'b0) begin
         errors++;
         $display("FAIL reset_data got=%h exp=0", {dp_in_flat, rsp_data, rsp_id});
      end
      rst = 1'b0;
      req_valid = '0;
      rsp_ready = 1'b0;
      step();
   endtask

   task automatic test_single();
      do_reset();
      req_data = '0;
      req_data[35:24] = 12'hA5C;
      req_valid = 4'b0100;
      #1;
      checks++;
      if (req_ready !== 4'b0100) begin
         errors++;
         $display("FAIL single_ready got=%b exp=0100", req_ready);
      end
      step();
      req_valid = '0;
      #1;
      checks++;
      if ({busy, rsp_valid, req_ready} !== 6'b100000) begin
         errors++;
         $display("FAIL single_issue got=%b exp=100000", {busy, rsp_valid, req_ready});
      end
      step();
      checks++;
      if ({rsp_valid, rsp_data, rsp_id} !== {1'b1, 12'hA5C, 2'd2}) begin
         errors++;
         $display("FAIL single_rsp got=%h exp=%h", {rsp_valid, rsp_data, rsp_id},
                  {1'b1, 12'hA5C, 2'd2});
      end
      checks++;
      if ({rsp_data[11:4], rsp_data[3:0]} !== {8'hA5, 4'hC}) begin
         errors++;
         $display("FAIL single_fields got a=%h b=%h exp a=a5 b=c", rsp_data[11:4], rsp_data[3:0]);
      end
      rsp_ready = 1'b1;
      step();
      checks++;
      if ({rsp_valid, busy} !== 2'b00) begin
         errors++;
         $display("FAIL single_done got=%b exp=00", {rsp_valid, busy});
      end
      rsp_ready = 1'b0;
   endtask

   task automatic test_fairness();
      logic [3:0] exp_rdy;
      int g;
      do_reset();
      req_data = {12'h004, 12'h003, 12'h002, 12'h001};
      req_valid = 4'hF;
      rsp_ready = 1'b1;
      for (int c = 0; c < 15; c++) begin
         #1;
         exp_rdy = (c % 3 == 0) ? 4'(1 << ((c / 3) % 4)) : 4'b0;
         checks++;
         if (req_ready !== exp_rdy) begin
            errors++;
            $display("FAIL fair_ready cyc=%0d got=%b exp=%b", c, req_ready, exp_rdy);
         end
         checks++;
         if (rsp_valid !== (c % 3 == 2)) begin
            errors++;
            $display("FAIL fair_valid cyc=%0d got=%b exp=%b", c, rsp_valid, (c % 3 == 2));
         end
         if (c % 3 == 2) begin
            g = ((c - 2) / 3) % 4;
            checks++;
            if ({rsp_id, rsp_data} !== {2'(g), 12'(g + 1)}) begin
               errors++;
               $display("FAIL fair_rsp cyc=%0d got=%h exp=%h", c, {rsp_id, rsp_data},
                        {2'(g), 12'(g + 1)});
            end
         end
         step();
      end
      req_valid = '0;
      rsp_ready = 1'b0;
      step();
   endtask

   task automatic test_backpressure();
      int n;
      do_reset();
      req_data = '0;
      req_data[11:0] = 12'h3C7;
      req_valid = 4'b0001;
      #1;
      checks++;
      if (req_ready !== 4'b0001) begin
         errors++;
         $display("FAIL bp_grant got=%b exp=0001", req_ready);
      end
      step();
      req_valid = 4'b1110;
      n = 0;
      while (rsp_valid !== 1'b1 && n < 10) begin
         step();
         n++;
      end
      checks++;
      if (n != 1) begin
         errors++;
         $display("FAIL bp_wait got=%0d exp=1", n);
      end
      for (int k = 0; k < 5; k++) begin
         #1;
         checks++;
         if ({rsp_valid, rsp_data, rsp_id, req_ready} !== {1'b1, 12'h3C7, 2'd0, 4'b0}) begin
            errors++;
            $display("FAIL bp_hold k=%0d got=%h exp=%h", k, {rsp_valid, rsp_data, rsp_id, req_ready},
                     {1'b1, 12'h3C7, 2'd0, 4'b0});
         end
         step();
      end
      rsp_ready = 1'b1;
      step();
      req_valid = '0;
      rsp_ready = 1'b0;
      checks++;
      if ({rsp_valid, busy} !== 2'b00) begin
         errors++;
         $display("FAIL bp_release got=%b exp=00", {rsp_valid, busy});
      end
`ifdef STRUCT_FLAT_ARB_STATS_EN
      checks++;
      if (stat_flat !== {16'd1, 16'd5}) begin
         errors++;
         $display("FAIL bp_stats got=%h exp=%h", stat_flat, {16'd1, 16'd5});
      end
`endif
   endtask

   task automatic test_lat4();
      int n;
      do_reset();
      l4_req_data = '0;
      l4_req_data[23:12] = 12'hFF0;
      l4_req_valid = 4'b0010;
      #1;
      checks++;
      if (l4_req_ready !== 4'b0010) begin
         errors++;
         $display("FAIL lat4_grant got=%b exp=0010", l4_req_ready);
      end
      step();
      l4_req_valid = '0;
      n = 1;
      while (l4_rsp_valid !== 1'b1 && n < 20) begin
         step();
         n++;
      end
      checks++;
      if (n != 5) begin
         errors++;
         $display("FAIL lat4_latency got=%0d exp=5", n);
      end
      checks++;
      if ({l4_rsp_data, l4_rsp_id} !== {12'hFF0, 2'd1}) begin
         errors++;
         $display("FAIL lat4_rsp got=%h exp=%h", {l4_rsp_data, l4_rsp_id}, {12'hFF0, 2'd1});
      end
      l4_rsp_ready = 1'b1;
      step();
      l4_rsp_ready = 1'b0;
   endtask

   task automatic test_rst_mid();
      int n;
      do_reset();
      req_data = {12'h333, 12'h777, 12'h111, 12'h000};
      req_valid = 4'b0100;
      step();
      req_valid = '0;
      rst = 1'b1;
      step();
      rst = 1'b0;
      checks++;
      if ({busy, rsp_valid, dp_in_flat} !== 14'b0) begin
         errors++;
         $display("FAIL rstmid_clear got=%h exp=0", {busy, rsp_valid, dp_in_flat});
      end
      rsp_ready = 1'b1;
      req_valid = 4'b1010;
      #1;
      checks++;
      if (req_ready !== 4'b0010) begin
         errors++;
         $display("FAIL rstmid_ptr got=%b exp=0010", req_ready);
      end
      step();
      req_valid = 4'b1000;
      n = 0;
      while (rsp_valid !== 1'b1 && n < 10) begin
         step();
         n++;
      end
      checks++;
      if ({rsp_valid, rsp_id, rsp_data} !== {1'b1, 2'd1, 12'h111}) begin
         errors++;
         $display("FAIL rstmid_rsp1 got=%h exp=%h", {rsp_valid, rsp_id, rsp_data},
                  {1'b1, 2'd1, 12'h111});
      end
      step();
      #1;
      checks++;
      if (req_ready !== 4'b1000) begin
         errors++;
         $display("FAIL rstmid_grant3 got=%b exp=1000", req_ready);
      end
      step();
      req_valid = '0;
      step();
      checks++;
      if ({rsp_valid, rsp_id, rsp_data} !== {1'b1, 2'd3, 12'h333}) begin
         errors++;
         $display("FAIL rstmid_rsp3 got=%h exp=%h", {rsp_valid, rsp_id, rsp_data},
                  {1'b1, 2'd3, 12'h333});
      end
      step();
      rsp_ready = 1'b0;
   endtask

   task automatic test_ptr_wrap();
      logic [3:0] exp_rdy;
      do_reset();
      req_data = {12'h00D, 12'h00C, 12'h00B, 12'h00A};
      req_valid = 4'b0010;
      rsp_ready = 1'b1;
      for (int c = 0; c < 9; c++) begin
         if (c == 1) req_valid = 4'b1010;
         #1;
         exp_rdy = (c == 0) ? 4'b0010 : (c == 3) ? 4'b1000 : (c == 6) ? 4'b0010 : 4'b0;
         checks++;
         if (req_ready !== exp_rdy) begin
            errors++;
            $display("FAIL ptr_order cyc=%0d got=%b exp=%b", c, req_ready, exp_rdy);
         end
         if (c == 5) begin
            checks++;
            if ({rsp_valid, rsp_id, rsp_data} !== {1'b1, 2'd3, 12'h00D}) begin
               errors++;
               $display("FAIL ptr_rsp3 got=%h exp=%h", {rsp_valid, rsp_id, rsp_data},
                        {1'b1, 2'd3, 12'h00D});
            end
         end
         step();
      end
      req_valid = '0;
      rsp_ready = 1'b0;
      step();
   endtask

   // Transaction-level model: pending requests, one outstanding job, round-robin pointer.
   task automatic test_random();
      bit         pend[4];
      logic [11:0] pdata[4];
      bit         outstanding = 0;
      int         age = 0, ptr = 0, w, exp_id = 0, done_n = 0, bp_n = 0;
      logic [11:0] exp_data = '0, exp_dp = '0;
      logic [3:0]  exp_rdy;
      bit          exp_rv;
      do_reset();
      for (int i = 0; i < 4; i++) begin
         pend[i] = 0;
         pdata[i] = '0;
      end
      for (int c = 0; c < 400; c++) begin
         for (int i = 0; i < 4; i++) begin
            if (!pend[i] && $urandom_range(0, 2) == 0) begin
               pend[i] = 1;
               pdata[i] = 12'($urandom);
            end else if (pend[i] && outstanding && $urandom_range(0, 9) == 0) begin
               pend[i] = 0;
            end
            req_valid[i] = pend[i];
            req_data[12*i +: 12] = pdata[i];
         end
         rsp_ready = 1'($urandom_range(0, 1));
         #1;
         w = -1;
         if (!outstanding) begin
            for (int k = 3; k >= 0; k--) if (pend[(ptr + k) % 4]) w = (ptr + k) % 4;
         end
         exp_rdy = (w >= 0) ? 4'(1 << w) : 4'b0;
         exp_rv = outstanding && (age >= 2);
         checks++;
         if ({req_ready, busy, rsp_valid, dp_in_flat} !== {exp_rdy, outstanding, exp_rv, exp_dp})
         begin
            errors++;
            $display("FAIL rand_ctrl cyc=%0d got=%h exp=%h", c,
                     {req_ready, busy, rsp_valid, dp_in_flat},
                     {exp_rdy, outstanding, exp_rv, exp_dp});
         end
         if (exp_rv) begin
            checks++;
            if ({rsp_id, rsp_data} !== {2'(exp_id), exp_data}) begin
               errors++;
               $display("FAIL rand_rsp cyc=%0d got=%h exp=%h", c, {rsp_id, rsp_data},
                        {2'(exp_id), exp_data});
            end
         end
         if (w >= 0) begin
            outstanding = 1;
            age = 1;
            exp_id = w;
            exp_data = pdata[w];
            exp_dp = pdata[w];
            pend[w] = 0;
            ptr = (w + 1) % 4;
         end else if (outstanding) begin
            if (age >= 2) begin
               if (rsp_ready) begin
                  outstanding = 0;
                  done_n++;
               end else begin
                  bp_n++;
               end
            end else begin
               age++;
            end
         end
         step();
      end
      req_valid = '0;
      rsp_ready = 1'b1;
      if (outstanding) done_n++;
      step();
      step();
      step();
      rsp_ready = 1'b0;
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL rand_drain got=%b exp=0", busy);
      end
`ifdef STRUCT_FLAT_ARB_STATS_EN
      checks++;
      if (stat_flat !== {16'(done_n), 16'(bp_n)}) begin
         errors++;
         $display("FAIL rand_stats got=%h exp=%h", stat_flat, {16'(done_n), 16'(bp_n)});
      end
`endif
   endtask

   initial begin
      test_reset();
      test_single();
      test_fairness();
      test_backpressure();
      test_lat4();
      test_rst_mid();
      test_ptr_wrap();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
